core_ctrl: RTL and testbench

CORE_CTRL -- requirements
Module: core_ctrl

---
 rtl/core_ctrl_pkg.sv | 41 ++++
 rtl/core_ctrl_addr_gen.sv | 18 +
 rtl/core_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_core_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared states, instruction bit map and constants for core_ctrl
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    K_L0,
    K_PE,
    GAP,
    A_L0,
    EXEC,
    DRAIN,
    NEXT,
    DONE
  } state_t;

  localparam int INST_W = 35;
  localparam int ADDR_W = 11;

  localparam int B_BYPASS   = 34;
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LSB   = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LSB   = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  localparam logic [INST_W-1:0] IDLE_WORD = (35'd1 << B_CEN_P) | (35'd1 << B_WEN_P) |
                                            (35'd1 << B_CEN_X) | (35'd1 << B_WEN_X);

  localparam logic [ADDR_W-1:0] W_BASE = 11'h400;
  localparam int GAP_CYCLES = 11;

endpackage

// File: rtl/core_ctrl_addr_gen.sv
// rtl/core_ctrl_addr_gen.sv - 11-bit base + step address, step saturating at a hold value
module core_ctrl_addr_gen
  import core_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_step,
  input  logic [ADDR_W-1:0] i_hold_at,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] w_off;

  always_comb begin
    w_off  = (i_step > i_hold_at) ? i_hold_at : i_step;
    o_addr = i_base + w_off;
  end

endmodule

// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - kij-pass sequencer issuing registered core instruction words
// Optional CORE_CTRL_PRUNE_SKIP_EN adds prune_mask input to skip masked kij passes.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int col      = 8,
  parameter int row      = 8,
  parameter int len_nij  = 36,
  parameter int len_onij = 16,
  parameter int len_kij  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
`ifdef CORE_CTRL_PRUNE_SKIP_EN
  input  logic [len_kij-1:0] prune_mask,
`endif
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij_idx
);

  localparam logic [15:0] C_KL0  = 16'(col);
  localparam logic [15:0] C_KPE  = 16'(col + row - 1);
  localparam logic [15:0] C_GAP  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] C_AL0  = 16'(len_nij);
  localparam logic [15:0] C_EXEC = 16'(row + col + len_nij - 1);
  localparam logic [15:0] C_DRN  = 16'(len_onij - 1);
  localparam logic [4:0]  C_NKIJ = 5'(len_kij);

  state_t              r_state;
  logic [15:0]         r_cnt;
  logic [3:0]          r_kij;
  logic [INST_W-1:0]   r_inst;
  logic                r_busy;
  logic                r_done;

  logic [INST_W-1:0]   w_inst;
  logic                w_last;
  state_t              w_succ;
  logic [4:0]          w_first;
  logic [4:0]          w_after;
  logic [ADDR_W-1:0]   w_xbase;
  logic [ADDR_W-1:0]   w_xhold;
  logic [ADDR_W-1:0]   w_ax;
  logic [ADDR_W-1:0]   w_pbase;
  logic [ADDR_W-1:0]   w_ap;

`ifdef CORE_CTRL_PRUNE_SKIP_EN
  function automatic logic [4:0] first_run(input logic [4:0] from,
                                           input logic [len_kij-1:0] mask);
    first_run = C_NKIJ;
    for (int k = 0; k < len_kij; k++) begin
      if (first_run == C_NKIJ && 5'(k) >= from && !mask[k]) first_run = 5'(k);
    end
  endfunction

  always_comb begin
    w_first = first_run(5'd0, prune_mask);
    w_after = first_run(5'(r_kij) + 5'd1, prune_mask);
  end
`else
  always_comb begin
    w_first = 5'd0;
    w_after = 5'(r_kij) + 5'd1;
  end
`endif

  always_comb begin
    w_xbase = (r_state == K_L0) ? W_BASE + 11'(r_kij) * 11'(col) : '0;
    w_xhold = (r_state == K_L0) ? 11'(col - 1) : 11'(len_nij - 1);
    w_pbase = 11'(r_kij) * 11'(len_onij);
  end

  core_ctrl_addr_gen u_xaddr (
    .i_base   (w_xbase),
    .i_step   (r_cnt[ADDR_W-1:0]),
    .i_hold_at(w_xhold),
    .o_addr   (w_ax)
  );

  core_ctrl_addr_gen u_paddr (
    .i_base   (w_pbase),
    .i_step   (r_cnt[ADDR_W-1:0]),
    .i_hold_at({ADDR_W{1'b1}}),
    .o_addr   (w_ap)
  );

  // End-of-phase detect for the linear phases; DRAIN only advances on accepted vectors.
  always_comb begin
    w_last = 1'b0;
    w_succ = r_state;
    case (r_state)
      K_L0:  begin w_last = (r_cnt == C_KL0);  w_succ = K_PE;  end
      K_PE:  begin w_last = (r_cnt == C_KPE);  w_succ = GAP;   end
      GAP:   begin w_last = (r_cnt == C_GAP);  w_succ = A_L0;  end
      A_L0:  begin w_last = (r_cnt == C_AL0);  w_succ = EXEC;  end
      EXEC:  begin w_last = (r_cnt == C_EXEC); w_succ = DRAIN; end
      DRAIN: begin w_last = ofifo_valid && (r_cnt == C_DRN); w_succ = NEXT; end
      default: ;
    endcase
  end

  always_comb begin
    w_inst = IDLE_WORD;
    case (r_state)
      K_L0: begin
        w_inst[B_CEN_X]              = 1'b0;
        w_inst[B_AX_LSB +: ADDR_W]   = w_ax;
        w_inst[B_L0_WR]              = (r_cnt != 16'd0);
      end
      K_PE: begin
        w_inst[B_LOAD]  = 1'b1;
        w_inst[B_L0_RD] = 1'b1;
      end
      A_L0: begin
        w_inst[B_CEN_X]              = (r_cnt == C_AL0);
        w_inst[B_AX_LSB +: ADDR_W]   = w_ax;
        w_inst[B_L0_WR]              = (r_cnt != 16'd0);
      end
      EXEC: begin
        w_inst[B_EXEC]  = 1'b1;
        w_inst[B_L0_RD] = 1'b1;
      end
      DRAIN: begin
        w_inst[B_BYPASS] = 1'b1;
        w_inst[B_ACC]    = 1'b0;
        if (ofifo_valid) begin
          w_inst[B_OFIFO_RD]         = 1'b1;
          w_inst[B_CEN_P]            = 1'b0;
          w_inst[B_WEN_P]            = 1'b0;
          w_inst[B_AP_LSB +: ADDR_W] = w_ap;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_kij   <= '0;
      r_inst  <= IDLE_WORD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_inst <= w_inst;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt <= '0;
            if (w_first >= C_NKIJ) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_kij   <= w_first[3:0];
              r_busy  <= 1'b1;
              r_state <= K_L0;
            end
          end
        end
        NEXT: begin
          r_cnt <= '0;
          if (w_after >= C_NKIJ) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_kij   <= w_after[3:0];
            r_state <= K_L0;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= w_succ;
          end else if (r_state != DRAIN || ofifo_valid) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  assign inst    = r_inst;
  assign busy    = r_busy;
  assign done    = r_done;
  assign kij_idx = r_kij;

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - scoreboard bench for core_ctrl (prune runs under CORE_CTRL_PRUNE_SKIP_EN)
module tb_core_ctrl;

  localparam int COL  = 8;
  localparam int ROW  = 8;
  localparam int NIJ  = 36;
  localparam int ONIJ = 16;
  localparam int KIJ  = 9;
  localparam int PER_KIJ = (COL + 1) + (COL + ROW) + 11 + (NIJ + 1) + (ROW + COL + NIJ) + ONIJ + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b1;
  logic [34:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;
`ifdef CORE_CTRL_PRUNE_SKIP_EN
  logic [KIJ-1:0] prune_mask = '0;
`endif

  core_ctrl #(.col(COL), .row(ROW), .len_nij(NIJ), .len_onij(ONIJ), .len_kij(KIJ)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ofifo_valid(ofifo_valid),
`ifdef CORE_CTRL_PRUNE_SKIP_EN
    .prune_mask (prune_mask),
`endif
    .inst       (inst),
    .busy       (busy),
    .done       (done),
    .kij_idx    (kij_idx)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [10:0] exp_pq[$];
  logic [10:0] exp_xq[$];
  bit          mon_en = 1'b0;
  bit          toggle_mode = 1'b0;
  int          wr_cnt = 0;
  int          l0w_cnt = 0;
  logic [34:0] idle_w;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [KIJ-1:0] mask);
    for (int k = 0; k < KIJ; k++) begin
      if (!mask[k]) begin
        for (int n = 0; n < ONIJ; n++) exp_pq.push_back(11'(k * ONIJ + n));
        for (int c = 0; c <= COL; c++) exp_xq.push_back(11'(1024 + k * COL + ((c < COL) ? c : COL - 1)));
      end
    end
  endtask

  task automatic pulse_start_and_wait(output int cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", busy, 1);
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1);
  endtask

  always @(negedge clk) ofifo_valid <= toggle_mode ? ~ofifo_valid : 1'b1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!inst[32] && !inst[31]) begin
        wr_cnt++;
        if (toggle_mode) check("wr_on_valid", ofifo_valid, 1);
        if (exp_pq.size() == 0) check("pmem_extra_write", wr_cnt, 0);
        else check("pmem_addr", inst[30:20], exp_pq.pop_front());
      end
      if (!inst[19] && inst[17]) begin
        if (exp_xq.size() == 0) check("xmem_extra_read", inst[17:7], 0);
        else check("xmem_w_addr", inst[17:7], exp_xq.pop_front());
      end
      if (inst[2] && inst[17]) l0w_cnt++;
    end
  end

  initial begin
    int cyc;
    int n;
    idle_w = '0;
    idle_w[32] = 1'b1;
    idle_w[31] = 1'b1;
    idle_w[19] = 1'b1;
    idle_w[18] = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_inst", inst, idle_w);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_kij", kij_idx, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_inst", inst, idle_w);

    // Run A: valid always high, fixed latency
    push_exp('0);
    wr_cnt = 0; l0w_cnt = 0; mon_en = 1'b1;
    pulse_start_and_wait(cyc);
    check("done_cycles", cyc, KIJ * PER_KIJ + 1);
    check("busy_at_done", busy, 0);
    check("kij_at_done", kij_idx, KIJ - 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    repeat (2) @(negedge clk);
    check("runA_writes", wr_cnt, KIJ * ONIJ);
    check("runA_l0_wr", l0w_cnt, KIJ * COL);
    check("runA_pq_empty", exp_pq.size(), 0);
    check("runA_xq_empty", exp_xq.size(), 0);

    // Run B: valid toggling, start re-pulsed while busy
    toggle_mode = 1'b1;
    push_exp('0);
    wr_cnt = 0; l0w_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (kij_idx != 4'd3 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reach_kij3", kij_idx, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_start_kij", kij_idx, 3);
    check("busy_start_busy", busy, 1);
    n = 0;
    while (!done && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check("runB_done", done, 1);
    toggle_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("runB_writes", wr_cnt, KIJ * ONIJ);
    check("runB_pq_empty", exp_pq.size(), 0);
    check("runB_xq_empty", exp_xq.size(), 0);
    mon_en = 1'b0;

    // Reset in the middle of EXEC
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!inst[1] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_exec", inst[1], 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_inst", inst, idle_w);
    check("midrst_busy", busy, 0);
    check("midrst_kij", kij_idx, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_inst", inst, idle_w);

    // Reset beats start in the same cycle
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_vs_start_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("rst_vs_start_idle", inst, idle_w);
    check("rst_vs_start_busy2", busy, 0);

`ifdef CORE_CTRL_PRUNE_SKIP_EN
    prune_mask = 9'b000001000;
    push_exp(9'b000001000);
    wr_cnt = 0; l0w_cnt = 0; mon_en = 1'b1;
    pulse_start_and_wait(cyc);
    check("prune_cycles", cyc, (KIJ - 1) * PER_KIJ + 1);
    repeat (2) @(negedge clk);
    check("prune_writes", wr_cnt, (KIJ - 1) * ONIJ);
    check("prune_pq_empty", exp_pq.size(), 0);
    check("prune_xq_empty", exp_xq.size(), 0);
    mon_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
